seg7_mux_display: RTL and testbench
===================================

Name: seg7_mux_display

Overview:
- Output-side counterpart of the keypad encoder path: takes an 8-bit result byte (e.g. ALU output) and drives a 2-digit, time-multiplexed, common-cathode 7-segment display.
- Shows the byte as two hex digits.
- Timing per digit: a dead-time blanking interval, then an on interval.
- New values are double-buffered and committed only at frame boundaries, so there is no tearing.

Parameters:
ON_CYCLES, 10000, clk cycles each digit is driven (≥1)
BLANK_CYCLES, 500, clk cycles of all-off dead time before each digit (≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  single-cycle strobe; captures data/dp_in into pending register
data  input  8  value to display; [3:0] → digit 0, [7:4] → digit 1
dp_in  input  1  decimal point request for digit 0 (e.g. zero flag)
lz_blank  input  1  level; blank digit 1 when its nibble is 0
seg  output  7  segment drive, active high; seg[0]=a … seg[6]=g
dp  output  1  decimal point drive, active high
digit_en  output  2  one-hot digit enable, active high; [0]=low nibble digit
frame_tick  output  1  one-cycle pulse at each frame commit

Behaviour:
- Reset (async, immediate):
  - state=BLANK, idx=0, timer=0.
  - pending=0, active=0, pending_dp=0, active_dp=0.
  - seg=0, dp=0, digit_en=0, frame_tick=0.
- All outputs are registered and change only on clk edges, except on reset assertion.
- State machine, two states:
  - BLANK: digit_en=0, seg=0, dp=0. Stay BLANK_CYCLES cycles, then go to SHOW with timer=0.
  - SHOW: digit_en = one-hot(idx). Stay ON_CYCLES cycles, then go to BLANK, toggle idx.
  - Leaving SHOW with idx=1 ends the frame: commit active←pending and active_dp←pending_dp, and pulse frame_tick.
  - frame_tick is high during the first BLANK cycle of the new frame.
- Sequence after reset release: B cycles blank, O cycles digit 0, B cycles blank, O cycles digit 1, repeat. Period = 2·(B+O) cycles.
- Segment values during SHOW:
  - idx=0: seg=hex7(active[3:0]), dp=active_dp.
  - idx=1: seg=hex7(active[7:4]), dp=0.
  - idx=1 with lz_blank=1 and active[7:4]=0: seg=0. digit_en[1] still asserted, so duty cycle is unchanged. lz_blank is sampled live.
- hex7 table, gfedcba order:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- load:
  - Updates pending on any cycle. Multiple loads in one frame: the last one wins.
  - Load on the same edge as a commit: the commit takes the old pending value; the new value is shown one frame later.
- Timer: width $clog2(max(ON_CYCLES,BLANK_CYCLES)). Counts 0..N-1 and wraps only on state change. No overflow is possible.
- Reset mid-frame: outputs go to 0 at once. After release, the sequence restarts at the BLANK of digit 0, and display content is 0x00.

Decomposition:
- Shared package:
  - state enum {BLANK, SHOW}.
  - 16-entry hex→segment constant table.
  - Segment bit-index constants SEG_A..SEG_G.
- Sub-module hex_to_seg7: combinational, 4-bit in → 7-bit out, table lookup. It is reused by any future display paths.

Test Plan:
All scenarios use ON_CYCLES=4, BLANK_CYCLES=2.
1. Reset release → outputs 0 for 2 cycles; then digit_en=01 and seg=3F for 4 cycles; 2 blank; digit_en=10 and seg=3F for 4 cycles; frame_tick high on cycle 12.
2. load data=3A, dp_in=1 mid-frame 0 → frame 0 still shows 3F/3F. Frame 1: digit0 seg=77 dp=1, digit1 seg=4F dp=0.
3. load 05 with lz_blank=1 → next frame: digit0 seg=6D; digit1 seg=00 with digit_en=10 still asserted. With lz_blank=0: digit1 seg=3F.
4. load 12 then load EF within one frame → next frame shows digit0=71 and digit1=79. The value 12 never appears.
5. load 81 on the exact frame_tick commit edge → following frame still shows the previous value. The frame after that shows digit0=06, digit1=7F.
6. Assert reset mid-SHOW asynchronously → seg, dp, digit_en and frame_tick are 0 before the next clk edge. After release, the display shows 00 and the scenario 1 timing repeats.

Source files
------------

// File: rtl/seg7_mux_display_pkg.sv
// ---------------------------------------------------------------------------
// seg7_mux_display_pkg
// Shared definitions for the multiplexed 7-segment display path:
//   - state_t      : display sequencer states (BLANK dead time, SHOW digit)
//   - SEG_A..SEG_G : bit positions of each segment within a 7-bit drive word
//   - HEX7_TABLE   : hex nibble -> segment pattern, gfedcba order, active high
// ---------------------------------------------------------------------------
package seg7_mux_display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Index = nibble value; glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_mux_display_hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex-nibble to 7-segment decoder (common cathode, active high).
// Ports:
//   i_hex [3:0] : nibble to display
//   o_seg [6:0] : segment pattern, o_seg[0]=a ... o_seg[6]=g
// ---------------------------------------------------------------------------
module hex_to_seg7
    import seg7_mux_display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = HEX7_TABLE[i_hex];
    end

endmodule

// File: rtl/seg7_mux_display.sv
// ---------------------------------------------------------------------------
// seg7_mux_display
// Drives a 2-digit, time-multiplexed, common-cathode 7-segment display with
// an 8-bit value shown as two hex digits. Each digit is preceded by a
// BLANK_CYCLES dead time and then driven for ON_CYCLES. New values are held
// in a pending register and committed to the displayed register only at the
// end of a frame (after digit 1), so a frame never mixes old and new data.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   load       : strobe, captures data/dp_in into the pending register
//   data [7:0] : value to display, [3:0] -> digit 0, [7:4] -> digit 1
//   dp_in      : decimal point request for digit 0
//   lz_blank   : blank digit 1 while its nibble is zero (sampled live)
//   seg [6:0]  : segment drive, active high, seg[0]=a ... seg[6]=g
//   dp         : decimal point drive, active high
//   digit_en   : one-hot digit enable, [0] = low-nibble digit
//   frame_tick : one-cycle pulse in the first BLANK cycle of each new frame
// ---------------------------------------------------------------------------
module seg7_mux_display
    import seg7_mux_display_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = 10000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       dp_in,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_en,
    output logic       frame_tick
);

    localparam int unsigned MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

    state_t        r_state, w_state_nxt;
    logic          r_idx, w_idx_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          w_commit;

    logic [7:0]    r_pending, r_active;
    logic          r_pending_dp, r_active_dp;

    logic [6:0]    r_seg, w_seg_nxt;
    logic          r_dp, w_dp_nxt;
    logic [1:0]    r_digit_en, w_digit_en_nxt;
    logic          r_frame_tick;

    logic [3:0]    w_nibble;
    logic [6:0]    w_hex_seg;

    // Sequencer: timer counts 0..N-1 within a state and restarts on every
    // state change, so it can never overflow.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer + 1'b1;
        w_commit    = 1'b0;
        case (r_state)
            BLANK: begin
                if (r_timer == BLANK_LAST) begin
                    w_state_nxt = SHOW;
                    w_timer_nxt = '0;
                end
            end
            SHOW: begin
                if (r_timer == ON_LAST) begin
                    w_state_nxt = BLANK;
                    w_timer_nxt = '0;
                    w_idx_nxt   = ~r_idx;
                    w_commit    = r_idx;
                end
            end
            default: begin
                w_state_nxt = BLANK;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign w_nibble = w_idx_nxt ? r_active[7:4] : r_active[3:0];

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_nibble),
        .o_seg (w_hex_seg)
    );

    // Outputs are decoded from the next state and registered. A commit only
    // happens when entering BLANK, so whenever the next state is SHOW the
    // current r_active is exactly what will be displayed.
    always_comb begin
        w_seg_nxt      = '0;
        w_dp_nxt       = 1'b0;
        w_digit_en_nxt = '0;
        if (w_state_nxt == SHOW) begin
            w_digit_en_nxt = w_idx_nxt ? 2'b10 : 2'b01;
            w_seg_nxt      = w_hex_seg;
            if (w_idx_nxt) begin
                if (lz_blank && (r_active[7:4] == 4'h0)) begin
                    w_seg_nxt = '0;
                end
            end else begin
                w_dp_nxt = r_active_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= BLANK;
            r_idx        <= 1'b0;
            r_timer      <= '0;
            r_pending    <= '0;
            r_active     <= '0;
            r_pending_dp <= 1'b0;
            r_active_dp  <= 1'b0;
            r_seg        <= '0;
            r_dp         <= 1'b0;
            r_digit_en   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_timer      <= w_timer_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_digit_en   <= w_digit_en_nxt;
            r_frame_tick <= w_commit;
            // A load on the commit edge lands in pending only; the commit
            // reads the old pending value.
            if (load) begin
                r_pending    <= data;
                r_pending_dp <= dp_in;
            end
            if (w_commit) begin
                r_active    <= r_pending;
                r_active_dp <= r_pending_dp;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign digit_en   = r_digit_en;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_mux_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_mux_display
// Directed bench for seg7_mux_display with ON_CYCLES=4, BLANK_CYCLES=2
// (frame = 12 cycles: 2 blank, 4 digit 0, 2 blank, 4 digit 1).
// Each table record describes one frame: up to two loads applied at given
// cycles of the frame, the lz_blank level, and the expected digit contents.
// Every cycle of every frame is compared against the expected pattern.
// ---------------------------------------------------------------------------
module tb_seg7_mux_display;

    localparam int unsigned ON = 4;
    localparam int unsigned BL = 2;
    localparam int FRAME = 2 * (ON + BL);

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] data;
    logic       dp_in;
    logic       lz_blank;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_en;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    seg7_mux_display #(
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data       (data),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         la;   // cycle of first load, -1 = none
        logic [7:0] da;
        logic       pa;
        int         lb;   // cycle of second load, -1 = none
        logic [7:0] db;
        logic       pb;
        logic       lz;
        logic [6:0] s0;   // expected digit 0 segments
        logic       d0;   // expected digit 0 decimal point
        logic [6:0] s1;   // expected digit 1 segments
        logic       t0;   // expected frame_tick in cycle 0
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {en,seg,dp,tick}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int f);
        for (int c = 0; c < FRAME; c++) begin
            logic [1:0] een;
            logic [6:0] es;
            logic       ed;
            lz_blank = v.lz;
            if (c == v.la) begin
                load = 1'b1; data = v.da; dp_in = v.pa;
            end else if (c == v.lb) begin
                load = 1'b1; data = v.db; dp_in = v.pb;
            end
            een = 2'b00; es = 7'h00; ed = 1'b0;
            if (c >= BL && c < BL + ON) begin
                een = 2'b01; es = v.s0; ed = v.d0;
            end else if (c >= 2 * BL + ON) begin
                een = 2'b10; es = v.s1;
            end
            check($sformatf("frame%0d_cyc%0d", f, c),
                  {digit_en, seg, dp, frame_tick},
                  {een, es, ed, (c == 0) ? v.t0 : 1'b0});
            step();
            load = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        //          la  da     pa    lb  db     pb    lz    s0     d0    s1     t0
        vecs[0] = '{-1, 8'h00, 1'b0, -1, 8'h00, 1'b0, 1'b0, 7'h3F, 1'b0, 7'h3F, 1'b0};
        vecs[1] = '{ 4, 8'h3A, 1'b1, -1, 8'h00, 1'b0, 1'b0, 7'h3F, 1'b0, 7'h3F, 1'b1};
        vecs[2] = '{ 3, 8'h05, 1'b0, -1, 8'h00, 1'b0, 1'b0, 7'h77, 1'b1, 7'h4F, 1'b1};
        vecs[3] = '{-1, 8'h00, 1'b0, -1, 8'h00, 1'b0, 1'b1, 7'h6D, 1'b0, 7'h00, 1'b1};
        vecs[4] = '{ 1, 8'h12, 1'b1,  9, 8'hEF, 1'b0, 1'b0, 7'h6D, 1'b0, 7'h3F, 1'b1};
        vecs[5] = '{11, 8'h81, 1'b0, -1, 8'h00, 1'b0, 1'b0, 7'h71, 1'b0, 7'h79, 1'b1};
        vecs[6] = '{-1, 8'h00, 1'b0, -1, 8'h00, 1'b0, 1'b0, 7'h71, 1'b0, 7'h79, 1'b1};
        vecs[7] = '{-1, 8'h00, 1'b0, -1, 8'h00, 1'b0, 1'b0, 7'h06, 1'b0, 7'h7F, 1'b1};

        reset = 1'b1; load = 1'b0; data = 8'h00; dp_in = 1'b0; lz_blank = 1'b0;
        #1;
        check("reset_state", {digit_en, seg, dp, frame_tick}, 11'h000);
        step();
        step();
        reset = 1'b0;

        for (int f = 0; f < 8; f++) begin
            run_frame(vecs[f], f);
        end

        // Mid-SHOW asynchronous reset: outputs must clear before the next edge.
        step(); step(); step();
        check("pre_reset_digit0", {digit_en, seg, dp, frame_tick}, {2'b01, 7'h06, 1'b0, 1'b0});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clear", {digit_en, seg, dp, frame_tick}, 11'h000);
        step();
        reset = 1'b0;

        rv = '{-1, 8'h00, 1'b0, -1, 8'h00, 1'b0, 1'b0, 7'h3F, 1'b0, 7'h3F, 1'b0};
        run_frame(rv, 8);
        rv.t0 = 1'b1;
        run_frame(rv, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
